// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces presses and releases,
// and emits one rdy pulse carrying the key code per accepted press.
module keypad_scanner #(
    parameter int CLK_DIV      = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypress,
    output logic       rdy,
    output logic       key_held
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CNT);
    // Nibble {row, col} holds the phone-layout code for that key.
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_t;
    state_t        r_state, w_next;
    logic [3:0]    r_sync, r_row_s, r_key;
    logic [DW-1:0] r_div;
    logic [1:0]    r_col, w_col_nx, r_sel_row, w_sel_nx, w_low_row;
    logic [CW-1:0] r_deb, w_deb_nx, r_rel, w_rel_nx, w_deb_inc, w_rel_inc;
    logic          w_tick, w_sel_level;
    assign w_tick      = r_div == DIV_MAX;
    assign w_low_row   = !r_row_s[0] ? 2'd0 : !r_row_s[1] ? 2'd1 : !r_row_s[2] ? 2'd2 : 2'd3;
    assign w_sel_level = r_row_s[r_sel_row];
    assign w_deb_inc   = r_deb + 1'b1;
    assign w_rel_inc   = r_rel + 1'b1;
    assign col_out     = ~(4'b0001 << r_col);
    assign keypress    = r_key;
    assign rdy         = r_state == EMIT;
    assign key_held    = r_state == EMIT || r_state == HOLD;
    always_comb begin
        w_next   = r_state;
        w_col_nx = r_col;
        w_sel_nx = r_sel_row;
        w_deb_nx = r_deb;
        w_rel_nx = r_rel;
        case (r_state)
            SCAN: if (w_tick) begin
                if (r_row_s != 4'hF) begin
                    w_sel_nx = w_low_row;
                    w_deb_nx = CW'(1);
                    w_next   = DEBOUNCE_CNT == 1 ? EMIT : DEBOUNCE;
                end else begin
                    w_col_nx = r_col + 2'd1;
                end
            end
            // A bounce drops back to SCAN on the same column so it is re-sampled next tick.
            DEBOUNCE: if (w_tick) begin
                if (!w_sel_level) begin
                    w_deb_nx = w_deb_inc;
                    w_next   = w_deb_inc == DEB_MAX ? EMIT : DEBOUNCE;
                end else begin
                    w_next = SCAN;
                end
            end
            EMIT: begin
                w_next   = HOLD;
                w_rel_nx = '0;
            end
            HOLD: if (w_tick) begin
                w_rel_nx = w_sel_level ? w_rel_inc : '0;
                if (w_sel_level && w_rel_inc == DEB_MAX) begin
                    w_next   = SCAN;
                    w_col_nx = r_col + 2'd1;
                end
            end
            default: w_next = SCAN;
        endcase
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sync    <= 4'hF;
            r_row_s   <= 4'hF;
            r_div     <= '0;
            r_state   <= SCAN;
            r_col     <= 2'd0;
            r_sel_row <= 2'd0;
            r_deb     <= '0;
            r_rel     <= '0;
            r_key     <= 4'd0;
        end else begin
            r_sync    <= row_in;
            r_row_s   <= r_sync;
            r_div     <= w_tick ? '0 : r_div + 1'b1;
            r_state   <= w_next;
            r_col     <= w_col_nx;
            r_sel_row <= w_sel_nx;
            r_deb     <= w_deb_nx;
            r_rel     <= w_rel_nx;
            if (w_next == EMIT && r_state != EMIT)
                r_key <= KEYMAP[{w_sel_nx, r_col, 2'b00} +: 4];
        end
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Transmitter side of the keypress/rdy interface consumed by the lock-control FSM.
- Scans a 4x4 active-low matrix keypad one column at a time, synchronizes and debounces row inputs, and encodes the pressed key into a 4-bit code.
- Emits exactly one single-cycle rdy pulse per debounced press; no repeat while held.

Parameters:
CLK_DIV, 1000, clk cycles per scan tick (column settle/sample period); must be >= 2
DEBOUNCE_CNT, 8, consecutive tick samples required to accept a press and to accept a release; must be >= 1

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous reset, active-low
row_in  input  4  keypad rows, active-low (pulled up), asynchronous to clk
col_out  output  4  column drive, active-low, exactly one bit low at all times
keypress  output  4  encoded key code, valid when rdy=1, held until next press
rdy  output  1  one-cycle pulse: new debounced key on keypress
key_held  output  1  high from the rdy cycle until release is debounced

Behaviour:
- Reset: asynchronous reset on resetN, active-low; clock clk. All flops reset.
  - Reset values: col_out=4'b1110 (column 0), keypress=0, rdy=0, key_held=0, state=SCAN.
  - Divider, debounce counters and synchronizer reset to idle; the synchronizer resets to 4'b1111.
  - Reset mid-press discards the press with no rdy.
- Synchronizer: row_in passes through a 2-flop synchronizer (row_s); all decisions use row_s only.
- Tick: the divider counts 0..CLK_DIV-1; tick=1 in the cycle the count equals CLK_DIV-1. The divider free-runs in all states.
- Key map (row r, column c), phone layout:
  - r0: 1 2 3 10
  - r1: 4 5 6 11
  - r2: 7 8 9 12
  - r3: 14 0 15 13
- FSM states: SCAN, DEBOUNCE, EMIT, HOLD.
- SCAN, on tick:
  - If any row_s bit is low: latch the lowest-index low row as sel_row and the current column as sel_col, set deb_cnt=1, go to DEBOUNCE. If DEBOUNCE_CNT=1, go directly to EMIT.
  - Otherwise rotate col_out to the next column, wrapping 3 to 0.
- DEBOUNCE, on tick:
  - If row_s[sel_row]=0: deb_cnt++. When deb_cnt reaches DEBOUNCE_CNT, go to EMIT.
  - If row_s[sel_row]=1 (bounce or glitch): go to SCAN, column not advanced, no rdy.
  - Other rows changing is ignored. col_out stays frozen on sel_col.
- EMIT, exactly one cycle:
  - rdy=1; keypress=map(sel_row, sel_col) is registered in the same cycle; key_held=1.
  - Next state is HOLD unconditionally.
- HOLD:
  - key_held=1, col_out frozen.
  - On each tick: if row_s[sel_row]=1 then rel_cnt++, else rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_CNT: key_held=0, rotate to the next column, go to SCAN.
  - A second key pressed during HOLD is ignored. Pressing it after the release is accepted means it is detected when its column is scanned.
- Latency: a clean, bounce-free press is detected at the first tick where its column is driven. rdy then follows DEBOUNCE_CNT-1 further ticks later, plus 1 cycle.
- Multiple rows low in the same column: the lowest row index wins.
- Multiple columns: only the driven column is ever observed.
- keypress changes only in the EMIT cycle. rdy is never high for two consecutive cycles.

Test Plan:
1. Reset, no keys, CLK_DIV=4, DEBOUNCE_CNT=3 -> col_out cycles 1110, 1101, 1011, 0111, 1110 every 4 clks; rdy stays 0; keypress=0.
2. Clean press at r2 c1 (key "8") held for 40 clks -> exactly one rdy pulse with keypress=8 and key_held=1. After release, key_held falls 3 ticks later and scanning resumes at column 2.
3. Bouncy press of r2 c0 (key "7"): low 1 tick, high 1 tick, then low steady -> first attempt returns to SCAN with no rdy; a single rdy with keypress=7 follows the stable period.
4. Hold r2 c2 (key "9") while r0 c0 is also pressed in another column -> one rdy with keypress=9 only. After r2 c2 is released, r0 c0 gives rdy with keypress=1.
5. Rows r1 and r3 both low in column 3 -> rdy with keypress=11 (lowest row wins).
6. Assert resetN=0 during DEBOUNCE of key "9", then release reset -> outputs return to their reset values; no rdy until a fresh full debounce completes.
